// File: rtl/i_writeback_pkg.sv
// Shared pipeline definitions for the writeback stage.
// Provides the data, register-address and counter widths used by every stage,
// the MEM/WB pipeline-register layout, and a helper that qualifies the
// register-file write enable.
package i_writeback_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 16;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memtoreg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  rd;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = {$bits(mem_wb_t){1'b0}};

  // A real instruction that writes a register other than r0.
  function automatic logic wb_write_en(input mem_wb_t s);
    return s.valid & s.regwrite & (s.rd != {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/i_writeback_mux.sv
// wb_mux: 32-bit 2:1 write-data selector for the writeback stage.
// Ports:
//   sel     - 1 selects in1 (load data), 0 selects in0 (ALU result)
//   in0/in1 - candidate write-data values
//   out     - selected write data
module wb_mux
  import i_writeback_pkg::*;
(
  input  logic              sel,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/i_writeback.sv
// i_writeback: MEM/WB pipeline register and writeback stage.
// Ports:
//   clk, rst_n                    - stage clock, synchronous active-low reset
//   MEM_WB_regwrite, MEM_WB_memtoreg, read_data, mem_alu_result,
//   mem_write_reg, mem_valid      - memory-stage results to be captured
//   stall, flush                  - hold / bubble-load the MEM/WB register
//   MEM_WB_rd, MEM_WB_regwrite_out,
//   WB_mux5_writedata             - register-file write port, feeds decode
//   wb_valid                      - writeback slot holds a real instruction
//   prev_rd, prev_data, prev_valid - last retired register write (forwarding)
//   retire_count                  - wrapping retired-instruction counter
module i_writeback
  import i_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEM_WB_regwrite,
  input  logic              MEM_WB_memtoreg,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [REG_W-1:0]  mem_write_reg,
  input  logic              mem_valid,
  input  logic              stall,
  input  logic              flush,
  output logic [REG_W-1:0]  MEM_WB_rd,
  output logic              MEM_WB_regwrite_out,
  output logic [DATA_W-1:0] WB_mux5_writedata,
  output logic              wb_valid,
  output logic [REG_W-1:0]  prev_rd,
  output logic [DATA_W-1:0] prev_data,
  output logic              prev_valid,
  output logic [CNT_W-1:0]  retire_count
);

  mem_wb_t           mem_wb_r;
  mem_wb_t           capture_s;
  logic              retire_s;
  logic [REG_W-1:0]  prev_rd_r;
  logic [DATA_W-1:0] prev_data_r;
  logic              prev_valid_r;
  logic [CNT_W-1:0]  retire_cnt_r;

  // Build the value captured on an unstalled edge; an empty slot becomes a bubble.
  always_comb begin
    capture_s = MEM_WB_BUBBLE;
    if (mem_valid) begin
      capture_s.valid      = 1'b1;
      capture_s.regwrite   = MEM_WB_regwrite;
      capture_s.memtoreg   = MEM_WB_memtoreg;
      capture_s.read_data  = read_data;
      capture_s.alu_result = mem_alu_result;
      capture_s.rd         = mem_write_reg;
    end else begin
      capture_s = MEM_WB_BUBBLE;
    end
  end

  // MEM/WB register: reset, then flush, then stall, then capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_wb_r <= MEM_WB_BUBBLE;
    end else if (flush) begin
      mem_wb_r <= MEM_WB_BUBBLE;
    end else if (stall) begin
      mem_wb_r <= mem_wb_r;
    end else begin
      mem_wb_r <= capture_s;
    end
  end

  wb_mux u_wb_mux (
    .sel (mem_wb_r.memtoreg),
    .in0 (mem_wb_r.alu_result),
    .in1 (mem_wb_r.read_data),
    .out (WB_mux5_writedata)
  );

  assign wb_valid            = mem_wb_r.valid;
  assign MEM_WB_regwrite_out = wb_write_en(mem_wb_r);
  assign MEM_WB_rd           = mem_wb_r.valid ? mem_wb_r.rd : {REG_W{1'b0}};

  // The slot leaves the stage on any unstalled edge, flush included, so a held
  // instruction is counted once, on the edge its stall drops.
  assign retire_s = mem_wb_r.valid & ~stall;

  // Forwarding record of the most recent retired register write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_rd_r    <= {REG_W{1'b0}};
      prev_data_r  <= {DATA_W{1'b0}};
      prev_valid_r <= 1'b0;
    end else if (retire_s && MEM_WB_regwrite_out) begin
      prev_rd_r    <= MEM_WB_rd;
      prev_data_r  <= WB_mux5_writedata;
      prev_valid_r <= 1'b1;
    end else begin
      prev_rd_r    <= prev_rd_r;
      prev_data_r  <= prev_data_r;
      prev_valid_r <= prev_valid_r;
    end
  end

  // Retired-instruction counter; wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign prev_rd      = prev_rd_r;
  assign prev_data    = prev_data_r;
  assign prev_valid   = prev_valid_r;
  assign retire_count = retire_cnt_r;

endmodule

// File: tb/tb_i_writeback.sv
// Directed self-checking bench for i_writeback.
module tb_i_writeback;

  logic        clk;
  logic        rst_n;
  logic        MEM_WB_regwrite;
  logic        MEM_WB_memtoreg;
  logic [31:0] read_data;
  logic [31:0] mem_alu_result;
  logic [4:0]  mem_write_reg;
  logic        mem_valid;
  logic        stall;
  logic        flush;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_regwrite_out;
  logic [31:0] WB_mux5_writedata;
  logic        wb_valid;
  logic [4:0]  prev_rd;
  logic [31:0] prev_data;
  logic        prev_valid;
  logic [15:0] retire_count;

  int n_cmp;
  int n_bad;

  i_writeback dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .MEM_WB_regwrite     (MEM_WB_regwrite),
    .MEM_WB_memtoreg     (MEM_WB_memtoreg),
    .read_data           (read_data),
    .mem_alu_result      (mem_alu_result),
    .mem_write_reg       (mem_write_reg),
    .mem_valid           (mem_valid),
    .stall               (stall),
    .flush               (flush),
    .MEM_WB_rd           (MEM_WB_rd),
    .MEM_WB_regwrite_out (MEM_WB_regwrite_out),
    .WB_mux5_writedata   (WB_mux5_writedata),
    .wb_valid            (wb_valid),
    .prev_rd             (prev_rd),
    .prev_data           (prev_data),
    .prev_valid          (prev_valid),
    .retire_count        (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [31:0] rdat, input logic [31:0] alu,
                       input logic [4:0] rd);
    mem_valid       = v;
    MEM_WB_regwrite = rw;
    MEM_WB_memtoreg = m2r;
    read_data       = rdat;
    mem_alu_result  = alu;
    mem_write_reg   = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444, 5'd9);
    cyc(); cyc();
    n_cmp++; if (MEM_WB_rd !== 5'd0) begin n_bad++; $display("FAIL reset_rd got %h want 0", MEM_WB_rd); end
    n_cmp++; if (MEM_WB_regwrite_out !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", MEM_WB_regwrite_out); end
    n_cmp++; if (WB_mux5_writedata !== 32'h0) begin n_bad++; $display("FAIL reset_wd got %h want 0", WB_mux5_writedata); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", wb_valid); end
    n_cmp++; if ({prev_valid, prev_rd, prev_data} !== 38'h0) begin n_bad++; $display("FAIL reset_prev got %b/%h/%h want 0", prev_valid, prev_rd, prev_data); end
    n_cmp++; if (retire_count !== 16'h0) begin n_bad++; $display("FAIL reset_cnt got %h want 0", retire_count); end
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_00AA, 5'd5);
    cyc();
    n_cmp++; if (MEM_WB_rd !== 5'd5) begin n_bad++; $display("FAIL alu_rd got %h want 05", MEM_WB_rd); end
    n_cmp++; if (MEM_WB_regwrite_out !== 1'b1) begin n_bad++; $display("FAIL alu_we got %b want 1", MEM_WB_regwrite_out); end
    n_cmp++; if (WB_mux5_writedata !== 32'h0000_00AA) begin n_bad++; $display("FAIL alu_wd got %h want 000000aa", WB_mux5_writedata); end
    n_cmp++; if (retire_count !== 16'd0 || prev_valid !== 1'b0) begin n_bad++; $display("FAIL alu_noretire got cnt %h pv %b want 0/0", retire_count, prev_valid); end
  endtask

  task automatic test_load_write();
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 5'd9);
    cyc();
    n_cmp++; if (WB_mux5_writedata !== 32'hDEAD_BEEF || MEM_WB_rd !== 5'd9) begin n_bad++; $display("FAIL load_wd got %h rd %h want deadbeef/09", WB_mux5_writedata, MEM_WB_rd); end
    n_cmp++; if (prev_rd !== 5'd5 || prev_data !== 32'hAA || prev_valid !== 1'b1) begin n_bad++; $display("FAIL alu_prev got %h/%h/%b want 05/000000aa/1", prev_rd, prev_data, prev_valid); end
    n_cmp++; if (retire_count !== 16'd1) begin n_bad++; $display("FAIL alu_cnt got %h want 1", retire_count); end
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
    cyc();
    n_cmp++; if (prev_rd !== 5'd9 || prev_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_prev got %h/%h want 09/deadbeef", prev_rd, prev_data); end
    n_cmp++; if (retire_count !== 16'd2) begin n_bad++; $display("FAIL load_cnt got %h want 2", retire_count); end
    n_cmp++; if (wb_valid !== 1'b0 || MEM_WB_rd !== 5'd0 || MEM_WB_regwrite_out !== 1'b0) begin n_bad++; $display("FAIL bubble got v %b rd %h we %b want 0/0/0", wb_valid, MEM_WB_rd, MEM_WB_regwrite_out); end
  endtask

  task automatic test_r0_write();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd0);
    cyc();
    n_cmp++; if (MEM_WB_regwrite_out !== 1'b0 || wb_valid !== 1'b1) begin n_bad++; $display("FAIL r0_we got we %b v %b want 0/1", MEM_WB_regwrite_out, wb_valid); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    cyc();
    n_cmp++; if (retire_count !== 16'd3) begin n_bad++; $display("FAIL r0_cnt got %h want 3", retire_count); end
    n_cmp++; if (prev_rd !== 5'd9 || prev_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL r0_prev got %h/%h want 09/deadbeef", prev_rd, prev_data); end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0077, 5'd7);
    cyc();
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0033, 5'd3);
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (MEM_WB_rd !== 5'd7 || WB_mux5_writedata !== 32'h77 || MEM_WB_regwrite_out !== 1'b1) begin n_bad++; $display("FAIL stall_hold%0d got %h/%h/%b want 07/00000077/1", i, MEM_WB_rd, WB_mux5_writedata, MEM_WB_regwrite_out); end
      n_cmp++; if (retire_count !== 16'd3) begin n_bad++; $display("FAIL stall_cnt%0d got %h want 3", i, retire_count); end
    end
    stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    cyc();
    n_cmp++; if (retire_count !== 16'd4 || prev_rd !== 5'd7 || prev_data !== 32'h77) begin n_bad++; $display("FAIL stall_retire got %h/%h/%h want 4/07/00000077", retire_count, prev_rd, prev_data); end
  endtask

  task automatic test_flush_stall();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00A0, 5'd10);
    cyc();
    flush = 1'b1; stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00B0, 5'd11);
    cyc();
    n_cmp++; if (wb_valid !== 1'b0 || MEM_WB_regwrite_out !== 1'b0) begin n_bad++; $display("FAIL flush_stall got v %b we %b want 0/0", wb_valid, MEM_WB_regwrite_out); end
    n_cmp++; if (retire_count !== 16'd4 || prev_rd !== 5'd7) begin n_bad++; $display("FAIL flush_stall_cnt got %h/%h want 4/07", retire_count, prev_rd); end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_flush_retire();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00C0, 5'd12);
    cyc();
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00D0, 5'd13);
    cyc();
    n_cmp++; if (retire_count !== 16'd5 || prev_rd !== 5'd12 || prev_data !== 32'hC0 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_retire got %h/%h/%h/%b want 5/0c/000000c0/0", retire_count, prev_rd, prev_data, wb_valid); end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00E0, 5'd14);
    cyc();
    stall = 1'b1;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    cyc();
    n_cmp++; if (retire_count !== 16'd0 || prev_valid !== 1'b0 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %h/%b/%b want 0/0/0", retire_count, prev_valid, wb_valid); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0001, 5'd0);
    // First edge only fills the slot; each later edge retires one.
    repeat (65536) cyc();
    n_cmp++; if (retire_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_pre got %h want ffff", retire_count); end
    cyc();
    n_cmp++; if (retire_count !== 16'h0000) begin n_bad++; $display("FAIL wrap got %h want 0000", retire_count); end
    drive(1'b1, 1'b1, 1'b1, 32'h5A5A_5A5A, 32'h1, 5'd20);
    cyc();
    rst_n = 1'b0;
    cyc();
    n_cmp++; if ({MEM_WB_rd, MEM_WB_regwrite_out, WB_mux5_writedata, wb_valid, prev_rd, prev_data, prev_valid, retire_count} !== 93'h0) begin n_bad++; $display("FAIL rst_stream got rd %h we %b wd %h v %b cnt %h", MEM_WB_rd, MEM_WB_regwrite_out, WB_mux5_writedata, wb_valid, retire_count); end
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    test_reset();
    test_alu_write();
    test_load_write();
    test_r0_write();
    test_stall();
    test_flush_stall();
    test_flush_retire();
    test_reset_mid_stall();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i_writeback.md
I_WRITEBACK -- requirements
Module: i_writeback

Interface
REQ-001 Clocking SHALL be one clock with a synchronous, active-low reset; all state updates on the rising edge of clk.
REQ-002 clk  input  1  stage clock.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 MEM_WB_regwrite  input  1  register-write control from the memory stage.
REQ-005 MEM_WB_memtoreg  input  1  1 = write load data, 0 = write ALU result.
REQ-006 read_data  input  32  data-memory read value.
REQ-007 mem_alu_result  input  32  ALU result passed through the memory stage.
REQ-008 mem_write_reg  input  5  destination register number.
REQ-009 mem_valid  input  1  memory-stage slot holds a real instruction.
REQ-010 stall  input  1  hold the MEM/WB register.
REQ-011 flush  input  1  load a bubble into the MEM/WB register.
REQ-012 MEM_WB_rd  output  5  register-file write address, feeds decode.
REQ-013 MEM_WB_regwrite_out  output  1  register-file write enable, feeds decode.
REQ-014 WB_mux5_writedata  output  32  register-file write data, feeds decode.
REQ-015 wb_valid  output  1  writeback slot holds a real instruction.
REQ-016 prev_rd / prev_data / prev_valid  output  5/32/1  previous retired write, for forwarding.
REQ-017 retire_count  output  16  retired-instruction counter.

Function
REQ-018 The MEM/WB register (valid, regwrite, memtoreg, read_data, alu_result, rd) SHALL capture inputs on every edge with rst_n=1, flush=0 and stall=0: one-cycle latency.
REQ-019 flush=1 SHALL load a bubble (all captured fields 0) regardless of stall; flush has priority over stall.
REQ-020 stall=1 with flush=0 SHALL hold every MEM/WB field unchanged.
REQ-021 mem_valid=0 SHALL capture as a bubble: valid=0, regwrite=0.
REQ-022 WB_mux5_writedata SHALL be the registered read_data when registered memtoreg=1, else the registered alu_result; this is combinational from the register.
REQ-023 MEM_WB_regwrite_out SHALL be valid AND regwrite AND (rd != 0); writes to register 0 are suppressed.
REQ-024 MEM_WB_rd SHALL equal the registered rd whenever valid=1, else 0.
REQ-025 An instruction SHALL retire on an edge where wb_valid=1 and stall=0; a stalled instruction retires exactly once, on the first unstalled edge.
REQ-026 On retirement with MEM_WB_regwrite_out=1, prev_rd/prev_data SHALL take MEM_WB_rd/WB_mux5_writedata and prev_valid SHALL become 1.
REQ-027 On retirement without a register write, the prev_* fields SHALL hold.
REQ-028 retire_count SHALL increment by 1 on each retirement and wrap from 16'hFFFF to 16'h0000.
REQ-029 With flush=1 and stall=0, the current wb instruction SHALL still retire while the bubble loads.

Reset
REQ-030 rst_n=0 at an edge SHALL clear all MEM/WB fields, prev_* and retire_count to 0, overriding stall and flush.
REQ-031 After reset, all outputs SHALL be 0 until the first valid capture.
REQ-032 A reset asserted mid-stall SHALL discard the held instruction without counting it.

Structure
REQ-033 Data width (32), register-address width (5) and counter width (16) SHALL be defined in the shared pipeline defines header used by all stages.
REQ-034 The write-data selection SHALL be one sub-module, wb_mux (32-bit 2:1 mux); all remaining logic stays in i_writeback.

Verification
REQ-035 ALU write: regwrite=1, memtoreg=0, alu=32'h0000_00AA, rd=5, valid=1 -> next cycle rd=5, regwrite_out=1, writedata=32'hAA.
REQ-036 Load write: memtoreg=1, read_data=32'hDEAD_BEEF, alu=32'h1 -> writedata=32'hDEAD_BEEF; on the following unstalled edge prev_rd=rd, prev_data=32'hDEAD_BEEF, retire_count +1.
REQ-037 r0 write: rd=0, regwrite=1 -> regwrite_out=0, retire_count still +1, prev_* unchanged.
REQ-038 Stall 3 cycles holding rd=7 -> outputs constant for 3 cycles, retire_count +1 only after stall drops.
REQ-039 flush=1 and stall=1 with valid input -> bubble loaded, wb_valid=0, regwrite_out=0 next cycle.
REQ-040 Counter preloaded to 16'hFFFF by 65535 retirements -> one more retirement gives 16'h0000; rst_n=0 mid-stream -> all outputs 0 next cycle.
